// File: rtl/vreg_access_sequencer_pkg.sv
// Shared vector-register crossbar types plus the sequencer's own state encoding.
package vreg_access_sequencer_pkg;

  localparam int VECTOR_REG_DEPTH  = 32;
  localparam int VECTOR_REG_WIDTH  = 32;
  localparam int NUM_OF_VECTOR_REG = 8;

  localparam int ADDR_W  = $clog2(VECTOR_REG_DEPTH);
  localparam int LEN_W   = $clog2(VECTOR_REG_DEPTH) + 1;
  localparam int OUTST_W = LEN_W;
  localparam int PTR_W   = $clog2(NUM_OF_VECTOR_REG);

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } access_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } vseq_state_t;

  typedef struct packed {
    logic                        vld;
    access_type_t                access_type;
    logic [PTR_W-1:0]            vec_reg_ptr;
    logic [ADDR_W-1:0]           addr;
    logic [LEN_W-1:0]            access_length;
    logic [VECTOR_REG_WIDTH-1:0] data;
  } cntrl_req_t;

  // Element address inside one register; wraps silently past the top entry.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  offset);
    return ADDR_W'({1'b0, base} + offset);
  endfunction

endpackage

// File: rtl/vreg_access_sequencer_if.sv
// One lane request port of the vector-register crossbar.
interface vreg_access_sequencer_if;
  import vreg_access_sequencer_pkg::*;

  cntrl_req_t req;
  logic       reg_req_grant;
  logic       rsp_vld;

  // Sequencer side: drives requests, sees grant and read responses.
  modport master (output req, input reg_req_grant, input rsp_vld);
  // Crossbar side.
  modport slave  (input req, output reg_req_grant, output rsp_vld);
endinterface

// File: rtl/vreg_access_sequencer.sv
// Turns one vector-register access command into per-element crossbar requests,
// tracks outstanding reads and pulses done when the whole access has retired.
module vreg_access_sequencer
  import vreg_access_sequencer_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_vld,
  output logic                        cmd_rdy,
  input  access_type_t                cmd_access_type,
  input  logic [PTR_W-1:0]            cmd_vec_reg_ptr,
  input  logic [ADDR_W-1:0]           cmd_base_addr,
  input  logic [LEN_W-1:0]            cmd_length,
  input  logic                        wdata_vld,
  input  logic [VECTOR_REG_WIDTH-1:0] wdata,
  output logic                        wdata_rdy,
  vreg_access_sequencer_if.master     xbar,
  output logic                        rd_elem_vld,
  output logic [LEN_W-1:0]            rd_elem_idx,
  output logic                        busy,
  output logic                        done,
  output logic                        err_rsp
);

  vseq_state_t        state_q, state_d;
  access_type_t       type_q, type_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [LEN_W-1:0]   returned_q, returned_d;
  logic [OUTST_W-1:0] outst_q, outst_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  cntrl_req_t req_c;
  logic       is_read;
  logic       grant;
  logic       rd_grant;
  logic       outst_nz;
  logic       rsp_accept;
  logic       last_grant;

  assign is_read = (type_q == READ_REQ);

  // Request is built only from registered state and the write-data source,
  // so grant/response never feed back into it within a cycle.
  always_comb begin
    req_c = '0;
    if (state_q == ISSUE) begin
      req_c.vld           = is_read ? 1'b1 : wdata_vld;
      req_c.access_type   = type_q;
      req_c.vec_reg_ptr   = ptr_q;
      req_c.addr          = elem_addr(base_q, issued_q);
      req_c.access_length = len_q - issued_q;
      req_c.data          = wdata;
    end
  end

  assign xbar.req    = req_c;
  assign grant       = req_c.vld & xbar.reg_req_grant;
  assign rd_grant    = grant & is_read;
  assign outst_nz    = (outst_q != '0);
  assign rsp_accept  = xbar.rsp_vld & outst_nz;
  assign last_grant  = grant & (issued_q == len_q - LEN_W'(1));

  assign wdata_rdy   = grant & ~is_read;
  assign rd_elem_vld = rsp_accept;
  assign rd_elem_idx = returned_q;
  assign cmd_rdy     = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err_rsp     = err_q;

  // Next-state, command latch and counter updates.
  always_comb begin
    // NOTE: every _d starts from its hold value so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    type_d     = type_q;
    ptr_d      = ptr_q;
    base_d     = base_q;
    len_d      = len_q;
    done_d     = 1'b0;
    err_d      = err_q | (xbar.rsp_vld & ~outst_nz);
    issued_d   = issued_q + LEN_W'(grant);
    returned_d = returned_q + LEN_W'(rsp_accept);
    outst_d    = outst_q;
    if (rd_grant && !rsp_accept)      outst_d = outst_q + OUTST_W'(1);
    else if (!rd_grant && rsp_accept) outst_d = outst_q - OUTST_W'(1);

    unique case (state_q)
      IDLE: begin
        if (cmd_vld) begin
          type_d     = cmd_access_type;
          ptr_d      = cmd_vec_reg_ptr;
          base_d     = cmd_base_addr;
          len_d      = cmd_length;
          issued_d   = '0;
          returned_d = '0;
          if (cmd_length == '0) done_d  = 1'b1;
          else                  state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (last_grant) begin
          if (!is_read || outst_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (outst_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; reset abandons any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      type_q     <= READ_REQ;
      ptr_q      <= '0;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      outst_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      type_q     <= type_d;
      ptr_q      <= ptr_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      outst_q    <= outst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_vreg_access_sequencer.sv
// Self-checking bench: each command is checked cycle by cycle against an
// element-list model (expected addresses, data, response order, done cycle).
module tb_vreg_access_sequencer;
  import vreg_access_sequencer_pkg::*;

  localparam int CYC_MAX = 1000;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        cmd_vld;
  logic                        cmd_rdy;
  access_type_t                cmd_access_type;
  logic [PTR_W-1:0]            cmd_vec_reg_ptr;
  logic [ADDR_W-1:0]           cmd_base_addr;
  logic [LEN_W-1:0]            cmd_length;
  logic                        wdata_vld;
  logic [VECTOR_REG_WIDTH-1:0] wdata;
  logic                        wdata_rdy;
  logic                        rd_elem_vld;
  logic [LEN_W-1:0]            rd_elem_idx;
  logic                        busy;
  logic                        done;
  logic                        err_rsp;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_err  = 1'b0;

  vreg_access_sequencer_if xbar_if ();

  vreg_access_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_vld         (cmd_vld),
    .cmd_rdy         (cmd_rdy),
    .cmd_access_type (cmd_access_type),
    .cmd_vec_reg_ptr (cmd_vec_reg_ptr),
    .cmd_base_addr   (cmd_base_addr),
    .cmd_length      (cmd_length),
    .wdata_vld       (wdata_vld),
    .wdata           (wdata),
    .wdata_rdy       (wdata_rdy),
    .xbar            (xbar_if),
    .rd_elem_vld     (rd_elem_vld),
    .rd_elem_idx     (rd_elem_idx),
    .busy            (busy),
    .done            (done),
    .err_rsp         (err_rsp)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    cmd_vld               = 1'b0;
    cmd_access_type       = READ_REQ;
    cmd_vec_reg_ptr       = '0;
    cmd_base_addr         = '0;
    cmd_length            = '0;
    wdata_vld             = 1'b0;
    wdata                 = '0;
    xbar_if.reg_req_grant = 1'b0;
    xbar_if.rsp_vld       = 1'b0;
  endtask

  // Runs one command to completion. Model: element i lives at (base+i) mod
  // depth; reads return in order; done comes one cycle after the last grant
  // (write) or the last response (read); length 0 completes one cycle after accept.
  task automatic run_cmd(input access_type_t t, input int ptr, input int base, input int len,
                         input int grant_pct, input int wvld_pct, input int rsp_max,
                         input int hold_elem, input int hold_cycles, input int wlow_cycles,
                         input bit b2b, input string name);
    logic [VECTOR_REG_WIDTH-1:0] wd[$];
    int  due_q[$];
    int  issued = 0, returned = 0, last_due = 0, finish = -1;
    int  held = 0, wlow = 0, wpulses = 0;
    bit  wpend = 1'b0, finished_ok = 1'b0;
    bit  is_rd = (t == READ_REQ);
    bit  g, wv, r, exp_vld, exp_busy, exp_done, in_issue;
    for (int i = 0; i < len; i++) wd.push_back($urandom);
    if (len == 0) finish = 0;

    if (!b2b) @(negedge clk);
    cmd_vld               = 1'b1;
    cmd_access_type       = t;
    cmd_vec_reg_ptr       = PTR_W'(ptr);
    cmd_base_addr         = ADDR_W'(base);
    cmd_length            = LEN_W'(len);
    wdata_vld             = 1'b0;
    xbar_if.reg_req_grant = 1'b0;
    xbar_if.rsp_vld       = 1'b0;
    #1;
    n_checks++;
    if (cmd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL %s accept cmd_rdy: got %b expected 1", name, cmd_rdy);
    end
    n_checks++;
    if (xbar_if.req.vld !== 1'b0) begin
      n_fail++; $display("FAIL %s accept req.vld: got %b expected 0", name, xbar_if.req.vld);
    end

    for (int k = 1; k <= CYC_MAX; k++) begin
      @(negedge clk);
      cmd_vld  = 1'b0;
      in_issue = (issued < len);
      if (in_issue && issued == hold_elem && held < hold_cycles) begin
        g = 1'b0; held++;
      end else begin
        g = ($urandom_range(0, 99) < grant_pct);
      end
      if (wpend)                    wv = 1'b1;
      else if (wlow < wlow_cycles) begin wv = 1'b0; wlow++; end
      else                          wv = ($urandom_range(0, 99) < wvld_pct);
      r = (due_q.size() > 0 && due_q[0] == k);
      if (r) void'(due_q.pop_front());
      xbar_if.reg_req_grant = g;
      xbar_if.rsp_vld       = r;
      wdata_vld             = wv;
      wdata                 = in_issue ? wd[issued] : $urandom;
      #1;

      exp_vld  = in_issue && (is_rd || wv);
      exp_busy = (len > 0) && (finish < 0 || k <= finish);
      exp_done = (finish >= 0) && (k == finish + 1);

      n_checks++;
      if (xbar_if.req.vld !== exp_vld) begin
        n_fail++; $display("FAIL %s c%0d req.vld: got %b expected %b", name, k, xbar_if.req.vld, exp_vld);
      end
      if (exp_vld) begin
        n_checks++;
        if (xbar_if.req.addr !== ADDR_W'((base + issued) % VECTOR_REG_DEPTH)) begin
          n_fail++; $display("FAIL %s c%0d req.addr: got %0d expected %0d", name, k,
                             xbar_if.req.addr, (base + issued) % VECTOR_REG_DEPTH);
        end
        n_checks++;
        if (xbar_if.req.access_type !== t || xbar_if.req.vec_reg_ptr !== PTR_W'(ptr)) begin
          n_fail++; $display("FAIL %s c%0d req type/ptr: got %0d/%0d expected %0d/%0d", name, k,
                             xbar_if.req.access_type, xbar_if.req.vec_reg_ptr, t, ptr);
        end
        n_checks++;
        if (xbar_if.req.access_length !== LEN_W'(len - issued)) begin
          n_fail++; $display("FAIL %s c%0d req.access_length: got %0d expected %0d", name, k,
                             xbar_if.req.access_length, len - issued);
        end
        if (!is_rd) begin
          n_checks++;
          if (xbar_if.req.data !== wd[issued]) begin
            n_fail++; $display("FAIL %s c%0d req.data: got %h expected %h", name, k,
                               xbar_if.req.data, wd[issued]);
          end
        end
      end
      n_checks++;
      if (wdata_rdy !== (exp_vld && g && !is_rd)) begin
        n_fail++; $display("FAIL %s c%0d wdata_rdy: got %b expected %b", name, k, wdata_rdy,
                           exp_vld && g && !is_rd);
      end
      if (wdata_rdy === 1'b1) wpulses++;
      n_checks++;
      if (rd_elem_vld !== r) begin
        n_fail++; $display("FAIL %s c%0d rd_elem_vld: got %b expected %b", name, k, rd_elem_vld, r);
      end
      if (r) begin
        n_checks++;
        if (rd_elem_idx !== LEN_W'(returned)) begin
          n_fail++; $display("FAIL %s c%0d rd_elem_idx: got %0d expected %0d", name, k, rd_elem_idx, returned);
        end
      end
      n_checks++;
      if (busy !== exp_busy || cmd_rdy !== !exp_busy) begin
        n_fail++; $display("FAIL %s c%0d busy/cmd_rdy: got %b/%b expected %b/%b", name, k,
                           busy, cmd_rdy, exp_busy, !exp_busy);
      end
      n_checks++;
      if (done !== exp_done) begin
        n_fail++; $display("FAIL %s c%0d done: got %b expected %b", name, k, done, exp_done);
      end
      n_checks++;
      if (err_rsp !== exp_err) begin
        n_fail++; $display("FAIL %s c%0d err_rsp: got %b expected %b", name, k, err_rsp, exp_err);
      end

      wpend = !is_rd && exp_vld && !g;
      if (exp_vld && g) begin
        issued++;
        if (is_rd) begin
          int due = k + $urandom_range(1, rsp_max);
          if (due <= last_due) due = last_due + 1;
          due_q.push_back(due);
          last_due = due;
        end else if (issued == len) begin
          finish = k;
        end
      end
      if (r) begin
        returned++;
        if (returned == len) finish = k;
      end
      if (exp_done) begin
        finished_ok = 1'b1;
        break;
      end
    end

    n_checks++;
    if (!finished_ok) begin
      n_fail++; $display("FAIL %s timeout: no completion within %0d cycles", name, CYC_MAX);
    end
    if (!is_rd) begin
      n_checks++;
      if (wpulses != len) begin
        n_fail++; $display("FAIL %s wdata_rdy pulses: got %0d expected %0d", name, wpulses, len);
      end
    end
    xbar_if.reg_req_grant = 1'b0;
    xbar_if.rsp_vld       = 1'b0;
    wdata_vld             = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (xbar_if.req !== '0) begin
      n_fail++; $display("FAIL reset req: got %h expected 0", xbar_if.req);
    end
    n_checks++;
    if (cmd_rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset cmd_rdy/busy/done: got %b/%b/%b expected 1/0/0", cmd_rdy, busy, done);
    end
    n_checks++;
    if (wdata_rdy !== 1'b0 || rd_elem_vld !== 1'b0 || err_rsp !== 1'b0) begin
      n_fail++; $display("FAIL reset wdata_rdy/rd_elem_vld/err_rsp: got %b/%b/%b expected 0/0/0",
                         wdata_rdy, rd_elem_vld, err_rsp);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    run_cmd(READ_REQ, 3, 0, 4, 100, 100, 1, -1, 0, 0, 1'b0, "t1_read");
  endtask

  task automatic test_write_wrap_stall();
    run_cmd(WRITE_REQ, 1, VECTOR_REG_DEPTH - 2, 3, 100, 100, 1, 1, 2, 0, 1'b0, "t2_write_wrap");
  endtask

  task automatic test_write_data_gaps();
    run_cmd(WRITE_REQ, 2, 5, 2, 100, 100, 1, -1, 0, 3, 1'b0, "t3_wdata_gap");
  endtask

  task automatic test_zero_length();
    run_cmd(READ_REQ, 0, 7, 0, 100, 100, 1, -1, 0, 0, 1'b0, "t4_len0");
  endtask

  task automatic test_reset_mid_issue();
    @(negedge clk);
    cmd_vld = 1'b1; cmd_access_type = READ_REQ; cmd_vec_reg_ptr = PTR_W'(5);
    cmd_base_addr = ADDR_W'(10); cmd_length = LEN_W'(8);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      cmd_vld = 1'b0;
      xbar_if.reg_req_grant = 1'b1;
      #1;
      n_checks++;
      if (xbar_if.req.vld !== 1'b1 || xbar_if.req.addr !== ADDR_W'(10 + k - 1)) begin
        n_fail++; $display("FAIL t5 pre-reset c%0d req vld/addr: got %b/%0d expected 1/%0d", k,
                           xbar_if.req.vld, xbar_if.req.addr, 10 + k - 1);
      end
    end
    #1;
    reset   = 1'b0;
    exp_err = 1'b0;
    #1;
    n_checks++;
    if (xbar_if.req.vld !== 1'b0 || busy !== 1'b0 || cmd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL t5 in-reset req.vld/busy/cmd_rdy: got %b/%b/%b expected 0/0/1",
                         xbar_if.req.vld, busy, cmd_rdy);
    end
    xbar_if.reg_req_grant = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL t5 post-reset c%0d done/busy: got %b/%b expected 0/0", k, done, busy);
      end
    end
    run_cmd(READ_REQ, 6, 20, 3, 100, 100, 2, -1, 0, 0, 1'b0, "t5_after_reset");
  endtask

  task automatic test_spurious_rsp();
    @(negedge clk);
    xbar_if.rsp_vld = 1'b1;
    #1;
    n_checks++;
    if (rd_elem_vld !== 1'b0 || err_rsp !== 1'b0) begin
      n_fail++; $display("FAIL t6 spurious rd_elem_vld/err_rsp: got %b/%b expected 0/0", rd_elem_vld, err_rsp);
    end
    exp_err = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      xbar_if.rsp_vld = 1'b0;
      #1;
      n_checks++;
      if (err_rsp !== 1'b1) begin
        n_fail++; $display("FAIL t6 err_rsp sticky c%0d: got %b expected 1", k, err_rsp);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(WRITE_REQ, 4, 30, 2, 100, 100, 1, -1, 0, 0, 1'b0, "b2b_w0");
    run_cmd(READ_REQ,  4, 1,  3, 100, 100, 2, -1, 0, 0, 1'b1, "b2b_r1");
    run_cmd(READ_REQ,  7, 0,  0, 100, 100, 1, -1, 0, 0, 1'b1, "b2b_len0");
    run_cmd(WRITE_REQ, 2, 9,  1, 100, 100, 1, -1, 0, 0, 1'b1, "b2b_w2");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      access_type_t t = ($urandom_range(0, 1) == 0) ? READ_REQ : WRITE_REQ;
      run_cmd(t, $urandom_range(0, NUM_OF_VECTOR_REG - 1), $urandom_range(0, VECTOR_REG_DEPTH - 1),
              $urandom_range(0, VECTOR_REG_DEPTH), $urandom_range(40, 100), $urandom_range(50, 100),
              $urandom_range(1, 4), $urandom_range(0, 8), $urandom_range(0, 3), $urandom_range(0, 2),
              bit'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_wrap_stall();
    test_write_data_gaps();
    test_zero_length();
    test_reset_mid_issue();
    test_spurious_rsp();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
